// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, imem request FSM and IF/ID register.
// Handles stalls with a one-word hold buffer and discards in-flight words on redirect.
module if_fetch_unit #(
    parameter logic [9:0]  RESET_PC  = 10'h000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Data_Hazard,
    input  logic        Control_Hazard,
    input  logic        jump,
    input  logic [9:0]  jump_address,
    input  logic        branch_taken,
    input  logic [9:0]  branch_address,
    output logic        imem_req,
    output logic [9:0]  imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [9:0]  pc_plus4,
    output logic [31:0] instr,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  pc_q, pc_d;
    logic [9:0]  old_q, old_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [9:0]  pc_plus4_q, pc_plus4_d;
    logic        if_valid_q, if_valid_d;

    logic [9:0]  pc_inc;
    logic [9:0]  target;

    assign pc_inc = pc_q + 10'd4;

    always_comb begin
        target = pc_q;
        if (jump) begin
            target = jump_address;
        end else if (branch_taken) begin
            target = branch_address;
        end
        target[1:0] = 2'b00;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        old_d      = old_q;
        buf_d      = buf_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        if_valid_d = if_valid_q;

        // A redirect flushes IF/ID regardless of stall or FSM state.
        if (Control_Hazard) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = 10'd0;
            if_valid_d = 1'b0;
            pc_d       = target;
        end

        unique case (state_q)
            S_REQ: begin
                if (Control_Hazard) begin
                    if (!imem_ready) begin
                        old_d   = pc_q;
                        state_d = S_DISCARD;
                    end
                end else if (imem_ready) begin
                    if (Data_Hazard) begin
                        instr_d    = imem_rdata;
                        pc_plus4_d = pc_inc;
                        if_valid_d = 1'b1;
                        pc_d       = pc_inc;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (Control_Hazard) begin
                    state_d = S_REQ;
                end else if (Data_Hazard) begin
                    instr_d    = buf_q;
                    pc_plus4_d = pc_inc;
                    if_valid_d = 1'b1;
                    pc_d       = pc_inc;
                    state_d    = S_REQ;
                end
            end
            S_DISCARD: begin
                if (!Control_Hazard && imem_ready) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            old_q      <= RESET_PC;
            buf_q      <= 32'd0;
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 10'd0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            old_q      <= old_d;
            buf_q      <= buf_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            if_valid_q <= if_valid_d;
        end
    end

    // The outstanding address stays on the bus while its word is being discarded.
    assign imem_req  = reset && (state_q != S_HOLD);
    assign imem_addr = (state_q == S_DISCARD) ? old_q : pc_q;
    assign pc_plus4  = pc_plus4_q;
    assign instr     = instr_q;
    assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stream, stall, redirect, priority,
// wrap-around and asynchronous reset during a discard.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        Data_Hazard;
    logic        Control_Hazard;
    logic        jump;
    logic [9:0]  jump_address;
    logic        branch_taken;
    logic [9:0]  branch_address;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [9:0]  pc_plus4;
    logic [31:0] instr;
    logic        if_valid;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_unit #(
        .RESET_PC (10'h000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Data_Hazard   (Data_Hazard),
        .Control_Hazard(Control_Hazard),
        .jump          (jump),
        .jump_address  (jump_address),
        .branch_taken  (branch_taken),
        .branch_address(branch_address),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .pc_plus4      (pc_plus4),
        .instr         (instr),
        .if_valid      (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: each word encodes its own address.
    assign imem_rdata = 32'hA000_0000 | {22'd0, imem_addr};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Control_Hazard = 1'b0;
        jump           = 1'b0;
        branch_taken   = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        Data_Hazard    = 1'b1;
        Control_Hazard = 1'b0;
        jump           = 1'b0;
        jump_address   = 10'd0;
        branch_taken   = 1'b0;
        branch_address = 10'd0;
        imem_ready     = 1'b1;

        #12;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc4", 32'(pc_plus4), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", 32'(imem_addr), 32'h000);

        // Stream
        tick();
        check("s0_instr", instr, 32'hA000_0000);
        check("s0_pc4", 32'(pc_plus4), 32'd4);
        check("s0_valid", 32'(if_valid), 32'd1);
        tick();
        check("s1_instr", instr, 32'hA000_0004);
        check("s1_pc4", 32'(pc_plus4), 32'd8);
        check("s1_addr", 32'(imem_addr), 32'd8);

        // Stall two cycles while fetching addr 8
        Data_Hazard = 1'b0;
        tick();
        check("st0_instr", instr, 32'hA000_0004);
        check("st0_pc4", 32'(pc_plus4), 32'd8);
        check("st0_req", 32'(imem_req), 32'd0);
        tick();
        check("st1_instr", instr, 32'hA000_0004);
        check("st1_req", 32'(imem_req), 32'd0);
        Data_Hazard = 1'b1;
        tick();
        check("st2_instr", instr, 32'hA000_0008);
        check("st2_pc4", 32'(pc_plus4), 32'd12);
        check("st2_valid", 32'(if_valid), 32'd1);
        check("st2_addr", 32'(imem_addr), 32'd12);
        check("st2_req", 32'(imem_req), 32'd1);
        tick();
        check("s3_instr", instr, 32'hA000_000C);
        check("s3_addr", 32'(imem_addr), 32'h010);

        // Redirect while request at 0x10 is outstanding
        imem_ready     = 1'b0;
        Control_Hazard = 1'b1;
        jump           = 1'b1;
        jump_address   = 10'h103;
        tick();
        check("rd_valid", 32'(if_valid), 32'd0);
        check("rd_instr", instr, 32'h0);
        check("rd_pc4", 32'(pc_plus4), 32'd0);
        check("rd_addr", 32'(imem_addr), 32'h010);
        check("rd_req", 32'(imem_req), 32'd1);
        idle();
        tick();
        check("rd1_addr", 32'(imem_addr), 32'h010);
        imem_ready = 1'b1;
        tick();
        check("rd2_valid", 32'(if_valid), 32'd0);
        check("rd2_instr", instr, 32'h0);
        check("rd2_addr", 32'(imem_addr), 32'h100);
        tick();
        check("rd3_instr", instr, 32'hA000_0100);
        check("rd3_pc4", 32'(pc_plus4), 32'h104);
        check("rd3_valid", 32'(if_valid), 32'd1);

        // Control hazard overrides stall
        Data_Hazard    = 1'b0;
        Control_Hazard = 1'b1;
        branch_taken   = 1'b1;
        branch_address = 10'h040;
        tick();
        check("pr_valid", 32'(if_valid), 32'd0);
        check("pr_instr", instr, 32'h0);
        check("pr_addr", 32'(imem_addr), 32'h040);
        idle();
        Data_Hazard = 1'b1;

        // Wrap at top of address space
        Control_Hazard = 1'b1;
        jump           = 1'b1;
        jump_address   = 10'h3FC;
        tick();
        check("wr_addr0", 32'(imem_addr), 32'h3FC);
        idle();
        tick();
        check("wr_instr", instr, 32'hA000_03FC);
        check("wr_pc4", 32'(pc_plus4), 32'h000);
        check("wr_addr1", 32'(imem_addr), 32'h000);

        // Refetch: hazard with no target keeps pc
        Control_Hazard = 1'b1;
        tick();
        check("rf_valid", 32'(if_valid), 32'd0);
        check("rf_addr", 32'(imem_addr), 32'h000);
        idle();
        tick();
        check("rf_instr", instr, 32'hA000_0000);
        check("rf_addr1", 32'(imem_addr), 32'h004);

        // Enter DISCARD at addr 4, then reset mid-request
        imem_ready     = 1'b0;
        Control_Hazard = 1'b1;
        jump           = 1'b1;
        jump_address   = 10'h200;
        tick();
        check("dr_addr", 32'(imem_addr), 32'h004);
        idle();
        #2;
        reset = 1'b0;
        #1;
        check("mr_req", 32'(imem_req), 32'd0);
        check("mr_addr", 32'(imem_addr), 32'h000);
        check("mr_instr", instr, 32'h0);
        check("mr_pc4", 32'(pc_plus4), 32'd0);
        check("mr_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        reset      = 1'b1;
        imem_ready = 1'b1;
        #1;
        check("mr_req1", 32'(imem_req), 32'd1);
        check("mr_addr1", 32'(imem_addr), 32'h000);
        tick();
        check("mr_instr1", instr, 32'hA000_0000);
        check("mr_valid1", 32'(if_valid), 32'd1);
        check("mr_addr2", 32'(imem_addr), 32'h004);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 10'h000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0000: value driven on instr when IF/ID is flushed or reset.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 Data_Hazard  input  1: 1 means the ID stage may advance; 0 means stall (hold PC and IF/ID).
REQ-006 Control_Hazard  input  1: 1 means flush IF/ID and redirect the PC.
REQ-007 jump  input  1: redirect target is jump_address.
REQ-008 jump_address  input  10: jump target byte address.
REQ-009 branch_taken  input  1: redirect target is branch_address.
REQ-010 branch_address  input  10: branch target byte address.
REQ-011 imem_req  output  1: instruction memory request.
REQ-012 imem_addr  output  10: instruction memory byte address.
REQ-013 imem_ready  input  1: imem_rdata is valid for the current request this cycle.
REQ-014 imem_rdata  input  32: instruction word.
REQ-015 pc_plus4  output  10: IF/ID register, fetched address + 4.
REQ-016 instr  output  32: IF/ID register, fetched instruction.
REQ-017 if_valid  output  1: IF/ID holds a real (non-flushed) instruction.

Function
REQ-018 The FSM SHALL have the states REQ, HOLD and DISCARD.
REQ-019 REQ: imem_req=1 and imem_addr=pc; imem_addr SHALL remain stable until imem_ready=1.
REQ-020 REQ with imem_ready=1 and Data_Hazard=1: IF/ID <= {pc+4, imem_rdata}, if_valid<=1, pc<=pc+4, FSM stays in REQ.
REQ-021 REQ with imem_ready=1 and Data_Hazard=0: imem_rdata SHALL be captured into the hold buffer, IF/ID and pc unchanged, next state HOLD.
REQ-022 HOLD: imem_req=0; when Data_Hazard=1, IF/ID <= {pc+4, buffer}, if_valid<=1, pc<=pc+4, next state REQ.
REQ-023 REQ with imem_ready=0: IF/ID and pc unchanged regardless of Data_Hazard.
REQ-024 Control_Hazard=1 SHALL override Data_Hazard in every state.
REQ-025 On Control_Hazard=1: instr<=NOP_INSTR, pc_plus4<=0, if_valid<=0.
REQ-026 Redirect target on Control_Hazard=1: jump_address if jump=1, else branch_address if branch_taken=1, else pc is unchanged (refetch).
REQ-027 Redirect target bits [1:0] SHALL be forced to 0.
REQ-028 Redirect in REQ with imem_ready=0 (request outstanding): pc <= target, next state DISCARD.
REQ-029 Redirect in REQ with imem_ready=1 or in HOLD: any arriving or held word is dropped, pc <= target, next state REQ.
REQ-030 DISCARD: imem_req=1 and imem_addr=old address held stable; on imem_ready=1 the word is dropped and the next state is REQ (new pc).
REQ-031 A second redirect during DISCARD SHALL update pc only; the state stays DISCARD.
REQ-032 PC arithmetic is modulo 1024: 10'h3FC + 4 = 10'h000, with no flag.
REQ-033 With imem_ready tied to 1 and no hazards, one instruction per cycle SHALL be delivered; the word requested in cycle N appears on instr in cycle N+1.
REQ-034 IF/ID outputs are registered; there is no combinational path from the imem inputs to instr, pc_plus4 or if_valid.

Reset
REQ-035 While reset=0, and asynchronously on assertion: pc=RESET_PC, state=REQ, instr=NOP_INSTR, pc_plus4=0, if_valid=0, hold buffer=0, imem_req=0.
REQ-036 The first cycle after reset rises SHALL drive imem_req=1 and imem_addr=RESET_PC.
REQ-037 Reset asserted mid-request SHALL abandon the request without a discard cycle.

Verification
REQ-038 Stream: imem_ready=1, rdata=0xA000_0000|addr -> instr sequence A0000000, A0000004, A0000008 with pc_plus4 4, 8, 12 on consecutive cycles, if_valid=1.
REQ-039 Stall: Data_Hazard=0 for 2 cycles while fetching addr 8 -> IF/ID holds addr 4, imem_req=0 in HOLD; on release instr=A0000008, pc_plus4=12.
REQ-040 Redirect while waiting: imem_ready=0 at addr 0x10, Control_Hazard=1, jump=1, jump_address=0x103 -> if_valid=0, instr=0; ready at 0x10 two cycles later is dropped; next imem_addr=0x100.
REQ-041 Priority: Data_Hazard=0 with Control_Hazard=1, branch_taken=1, branch_address=0x040 -> flush, imem_addr=0x040 next cycle.
REQ-042 Wrap: fetch at 0x3FC -> pc_plus4=0x000, next imem_addr=0x000.
REQ-043 Reset mid-run: reset=0 during DISCARD -> all outputs at reset values; after release imem_addr=RESET_PC, no word dropped.
